ysyx_25040129_axi_arbiter: RTL and testbench

YSYX_25040129_AXI_ARBITER -- requirements
Module: ysyx_25040129_axi_arbiter

---
 rtl/ysyx_25040129_axi_pkg.sv | 19 +
 rtl/ysyx_25040129_rr_arb2.sv | 34 +++
 rtl/ysyx_25040129_axi_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_25040129_axi_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_axi_pkg.sv
// Shared types for the IFU/LSU to single-master AXI arbiter:
// transaction-state and grant enumerations plus fixed ID width.
package ysyx_25040129_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_IFU = 2'd1,
        ST_RD_LSU = 2'd2,
        ST_WR     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    localparam int unsigned ID_W = 4;

endpackage

// File: rtl/ysyx_25040129_rr_arb2.sv
// Two-way round-robin picker: one-hot grant from the request pair, with a
// pointer that remembers the last side granted (bit 0 = IFU, bit 1 = LSU).
module ysyx_25040129_rr_arb2
    import ysyx_25040129_axi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    grant_t last_grant;

    // On a tie the side that was not served last wins.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == GRANT_IFU) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_IFU;
        end else if (update && (grant != '0)) begin
            last_grant <= grant[1] ? GRANT_LSU : GRANT_IFU;
        end
    end

endmodule

// File: rtl/ysyx_25040129_axi_arbiter.sv
// Arbitrates IFU reads and LSU reads/writes onto one AXI master port,
// one outstanding transaction at a time, with a registered grant.
module ysyx_25040129_axi_arbiter
    import ysyx_25040129_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic [7:0]            ifu_arlen,
    input  logic [2:0]            ifu_arsize,
    input  logic [1:0]            ifu_arburst,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rlast,

    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic [7:0]            lsu_arlen,
    input  logic [2:0]            lsu_arsize,
    input  logic [1:0]            lsu_arburst,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rlast,

    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic [7:0]            lsu_awlen,
    input  logic [2:0]            lsu_awsize,
    input  logic [1:0]            lsu_awburst,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wlast,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [1:0]            lsu_bresp,

    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ID_W-1:0]       io_master_arid,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [ID_W-1:0]       io_master_rid,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast,

    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ID_W-1:0]       io_master_awid,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [ID_W-1:0]       io_master_bid,
    input  logic [1:0]            io_master_bresp
);

    arb_state_t state, state_nxt;
    logic       ar_done, aw_done, w_done;
    logic [1:0] req, grant;
    logic       rd_lsu;
    logic       ar_hs, r_fin, aw_hs, w_hs, b_fin;
    logic       unused_ids;

    assign unused_ids = ^{io_master_rid, io_master_bid};

    assign req = {lsu_arvalid | lsu_awvalid, ifu_arvalid};

    ysyx_25040129_rr_arb2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .update (state == ST_IDLE),
        .grant  (grant)
    );

    assign ar_hs = io_master_arvalid & io_master_arready;
    assign r_fin = io_master_rvalid & io_master_rready & io_master_rlast;
    assign aw_hs = io_master_awvalid & io_master_awready;
    assign w_hs  = io_master_wvalid & io_master_wready;
    assign b_fin = io_master_bvalid & io_master_bready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (ar_hs)                   ar_done <= 1'b1;
                if (aw_hs)                   aw_done <= 1'b1;
                if (w_hs && io_master_wlast) w_done  <= 1'b1;
            end
        end
    end

    // Within the LSU a pending write outranks a pending read.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant[1])      state_nxt = lsu_awvalid ? ST_WR : ST_RD_LSU;
                else if (grant[0]) state_nxt = ST_RD_IFU;
            end
            ST_RD_IFU, ST_RD_LSU: if (r_fin) state_nxt = ST_IDLE;
            ST_WR:                if (b_fin) state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    // Payload fields are routed unconditionally; only valid/ready are gated.
    assign rd_lsu            = (state == ST_RD_LSU);
    assign io_master_arid    = '0;
    assign io_master_araddr  = rd_lsu ? lsu_araddr  : ifu_araddr;
    assign io_master_arlen   = rd_lsu ? lsu_arlen   : ifu_arlen;
    assign io_master_arsize  = rd_lsu ? lsu_arsize  : ifu_arsize;
    assign io_master_arburst = rd_lsu ? lsu_arburst : ifu_arburst;
    assign ifu_rdata         = io_master_rdata;
    assign ifu_rresp         = io_master_rresp;
    assign ifu_rlast         = io_master_rlast;
    assign lsu_rdata         = io_master_rdata;
    assign lsu_rresp         = io_master_rresp;
    assign lsu_rlast         = io_master_rlast;
    assign io_master_awid    = '0;
    assign io_master_awaddr  = lsu_awaddr;
    assign io_master_awlen   = lsu_awlen;
    assign io_master_awsize  = lsu_awsize;
    assign io_master_awburst = lsu_awburst;
    assign io_master_wdata   = lsu_wdata;
    assign io_master_wstrb   = lsu_wstrb;
    assign io_master_wlast   = lsu_wlast;
    assign lsu_bresp         = io_master_bresp;

    always_comb begin
        ifu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        lsu_arready       = 1'b0;
        lsu_rvalid        = 1'b0;
        lsu_awready       = 1'b0;
        lsu_wready        = 1'b0;
        lsu_bvalid        = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        case (state)
            ST_RD_IFU: begin
                io_master_arvalid = ifu_arvalid & ~ar_done;
                ifu_arready       = io_master_arready & ~ar_done;
                ifu_rvalid        = io_master_rvalid;
                io_master_rready  = ifu_rready;
            end
            ST_RD_LSU: begin
                io_master_arvalid = lsu_arvalid & ~ar_done;
                lsu_arready       = io_master_arready & ~ar_done;
                lsu_rvalid        = io_master_rvalid;
                io_master_rready  = lsu_rready;
            end
            ST_WR: begin
                io_master_awvalid = lsu_awvalid & ~aw_done;
                lsu_awready       = io_master_awready & ~aw_done;
                io_master_wvalid  = lsu_wvalid & ~w_done;
                lsu_wready        = io_master_wready & ~w_done;
                lsu_bvalid        = io_master_bvalid;
                io_master_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// Randomized bench for the AXI arbiter: upstream drivers, a downstream slave
// model, and a request-list model of the grant order.
module tb_ysyx_25040129_axi_arbiter;

    logic        clock, reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic [3:0]  lsu_wstrb;
    logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready;
    logic        io_master_rlast, io_master_awvalid, io_master_awready, io_master_wvalid;
    logic        io_master_wready, io_master_wlast, io_master_bvalid, io_master_bready;
    logic [3:0]  io_master_arid, io_master_rid, io_master_awid, io_master_bid, io_master_wstrb;
    logic [31:0] io_master_araddr, io_master_rdata, io_master_awaddr, io_master_wdata;
    logic [7:0]  io_master_arlen, io_master_awlen;
    logic [2:0]  io_master_arsize, io_master_awsize;
    logic [1:0]  io_master_arburst, io_master_rresp, io_master_awburst, io_master_bresp;

    ysyx_25040129_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_arid(io_master_arid), .io_master_araddr(io_master_araddr),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rid(io_master_rid), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_awid(io_master_awid), .io_master_awaddr(io_master_awaddr),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
        .io_master_bid(io_master_bid), .io_master_bresp(io_master_bresp)
    );

    int n_chk = 0;
    int n_bad = 0;
    int last_side = 0;          // 0 = IFU served last, 1 = LSU
    int got_q[$];               // 0 IFU read, 1 LSU read, 2 LSU write
    int exp_q[$];
    logic [1:0]  last_resp = 2'b00;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [31:0] s_waddr;
    logic [7:0]  s_wlen;
    logic [31:0] s_wd[$];
    logic [3:0]  s_ws[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a, input int b);
        return a ^ (32'h01010101 * b) ^ 32'hA5A50000;
    endfunction

    function automatic logic [11:0] outs();
        return {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, io_master_arvalid, io_master_rready, io_master_awvalid,
                io_master_wvalid, io_master_bready};
    endfunction

    // Grant order for requests all present together in IDLE.
    task automatic predict(input bit i, input bit lr, input bit lw);
        int side;
        while (i || lr || lw) begin
            if (i && (lr || lw)) side = (last_side == 0) ? 1 : 0;
            else                 side = i ? 0 : 1;
            if (side == 0)   begin exp_q.push_back(0); i  = 1'b0; end
            else if (lw)     begin exp_q.push_back(2); lw = 1'b0; end
            else             begin exp_q.push_back(1); lr = 1'b0; end
            last_side = side;
        end
    endtask

    task automatic compare_order();
        check_eq("order_len", got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            check_eq("order", got_q[k], exp_q[k]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Downstream slave: random readies, bursts of exp_rdata, B after AW and last W.
    initial begin : slave
        bit rd_act, aw_got, w_got, b_pend;
        logic [31:0] rd_addr;
        logic [7:0]  rd_len, rd_beat;
        rd_act = 0; aw_got = 0; w_got = 0; b_pend = 0;
        rd_addr = '0; rd_len = '0; rd_beat = '0;
        io_master_rid = 4'hF; io_master_bid = 4'hF;
        {io_master_arready, io_master_rvalid, io_master_awready, io_master_wready, io_master_bvalid} = '0;
        io_master_rdata = '0; io_master_rresp = '0; io_master_rlast = 1'b0; io_master_bresp = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                rd_act = 0; aw_got = 0; w_got = 0; b_pend = 0;
                {io_master_arready, io_master_rvalid, io_master_awready, io_master_wready, io_master_bvalid} = '0;
                io_master_rlast = 1'b0;
            end else begin
                io_master_arready = !rd_act && ($urandom_range(0, 3) != 0);
                io_master_rvalid  = rd_act && ($urandom_range(0, 3) != 0);
                io_master_rdata   = exp_rdata(rd_addr, int'(rd_beat));
                io_master_rlast   = rd_act && (rd_beat == rd_len);
                io_master_rresp   = (rd_beat == rd_len) ? last_resp : 2'b00;
                io_master_awready = !aw_got && ($urandom_range(0, 2) != 0);
                io_master_wready  = !w_got && ($urandom_range(0, 2) != 0);
                io_master_bvalid  = b_pend;
                io_master_bresp   = b_resp_cfg;
                #4;
                if (!reset) begin
                    if (io_master_rvalid && io_master_rready) begin
                        if (rd_beat == rd_len) rd_act = 0;
                        else rd_beat = rd_beat + 8'd1;
                    end
                    if (io_master_arvalid && io_master_arready) begin
                        check_eq("arid", io_master_arid, 0);
                        check_eq("arsize", io_master_arsize, 3'd2);
                        rd_addr = io_master_araddr; rd_len = io_master_arlen;
                        rd_beat = '0; rd_act = 1;
                    end
                    if (io_master_bvalid && io_master_bready) begin
                        b_pend = 0; aw_got = 0; w_got = 0;
                    end
                    if (io_master_awvalid && io_master_awready) begin
                        check_eq("awid", io_master_awid, 0);
                        aw_got = 1; s_waddr = io_master_awaddr; s_wlen = io_master_awlen;
                    end
                    if (io_master_wvalid && io_master_wready) begin
                        s_wd.push_back(io_master_wdata);
                        s_ws.push_back(io_master_wstrb);
                        if (io_master_wlast) w_got = 1;
                    end
                    if (aw_got && w_got && !b_pend && !io_master_bvalid) b_pend = 1;
                end
            end
        end
    end

    task automatic rd_req(input int who, input logic [31:0] addr, input logic [7:0] len, input bit chk_lat);
        int n, beat;
        bit acc, done;
        logic av, ar, rv, rr, rl, orv;
        logic [31:0] rd;
        logic [1:0] rp;
        @(negedge clock);
        if (who == 0) begin
            ifu_arvalid = 1; ifu_araddr = addr; ifu_arlen = len;
            ifu_arsize = 3'd2; ifu_arburst = 2'b01; ifu_rready = 1'($urandom_range(0, 1));
        end else begin
            lsu_arvalid = 1; lsu_araddr = addr; lsu_arlen = len;
            lsu_arsize = 3'd2; lsu_arburst = 2'b01; lsu_rready = 1'($urandom_range(0, 1));
        end
        n = 0; beat = 0; acc = 0; done = 0;
        while (!done && n < 400) begin
            #4;
            if (chk_lat && n == 0) check_eq("lat_idle", io_master_arvalid, 0);
            if (chk_lat && n == 1) begin
                check_eq("lat_fwd", io_master_arvalid, 1);
                check_eq("araddr", io_master_araddr, addr);
                check_eq("arlen", io_master_arlen, len);
            end
            if (who == 0) begin
                av = ifu_arvalid; ar = ifu_arready; rv = ifu_rvalid; rr = ifu_rready;
                rd = ifu_rdata; rp = ifu_rresp; rl = ifu_rlast; orv = lsu_rvalid;
            end else begin
                av = lsu_arvalid; ar = lsu_arready; rv = lsu_rvalid; rr = lsu_rready;
                rd = lsu_rdata; rp = lsu_rresp; rl = lsu_rlast; orv = ifu_rvalid;
            end
            if (av && ar) begin
                acc = 1;
                got_q.push_back(who);
            end
            if (rv && rr) begin
                check_eq(who == 0 ? "ifu_rdata" : "lsu_rdata", rd, exp_rdata(addr, beat));
                check_eq("rlast", rl, beat == int'(len));
                check_eq("rresp", rp, (beat == int'(len)) ? last_resp : 2'b00);
                check_eq("rvalid_other", orv, 0);
                if (beat == int'(len)) done = 1;
                beat++;
            end
            @(negedge clock);
            if (who == 0) begin
                if (acc) ifu_arvalid = 0;
                ifu_rready = ($urandom_range(0, 3) != 0);
            end else begin
                if (acc) lsu_arvalid = 0;
                lsu_rready = ($urandom_range(0, 3) != 0);
            end
            n++;
        end
        if (!done) check_eq("rd_timeout", 0, 1);
        if (who == 0) begin ifu_arvalid = 0; ifu_rready = 0; end
        else          begin lsu_arvalid = 0; lsu_rready = 0; end
    endtask

    task automatic wr_req(input logic [31:0] addr, input int nb, input int lead,
                          input logic [31:0] d0, input logic [3:0] s0, input bit rnd);
        logic [31:0] wd[$];
        logic [3:0]  ws[$];
        int c, wi;
        bit aw_ok, done;
        for (int k = 0; k < nb; k++) begin
            wd.push_back((k == 0 && !rnd) ? d0 : $urandom);
            ws.push_back((k == 0 && !rnd) ? s0 : 4'($urandom_range(1, 15)));
        end
        s_wd.delete();
        s_ws.delete();
        @(negedge clock);
        lsu_awaddr = addr; lsu_awlen = 8'(nb - 1); lsu_awsize = 3'd2; lsu_awburst = 2'b01;
        lsu_awvalid = (lead == 0);
        lsu_wvalid = 1; lsu_wdata = wd[0]; lsu_wstrb = ws[0]; lsu_wlast = (nb == 1);
        lsu_bready = 1'($urandom_range(0, 1));
        c = 0; wi = 0; aw_ok = 0; done = 0;
        while (!done && c < 400) begin
            #4;
            if (lsu_awvalid && lsu_awready) begin
                aw_ok = 1;
                got_q.push_back(2);
            end
            if (lsu_wvalid && lsu_wready) wi++;
            if (lsu_bvalid && lsu_bready) begin
                check_eq("bresp", lsu_bresp, b_resp_cfg);
                done = 1;
            end
            @(negedge clock);
            c++;
            if (aw_ok)          lsu_awvalid = 0;
            else if (c >= lead) lsu_awvalid = 1;
            if (wi < nb) begin
                lsu_wvalid = 1; lsu_wdata = wd[wi]; lsu_wstrb = ws[wi]; lsu_wlast = (wi == nb - 1);
            end else begin
                lsu_wvalid = 0; lsu_wlast = 0;
            end
            lsu_bready = ($urandom_range(0, 3) != 0);
        end
        if (!done) check_eq("wr_timeout", 0, 1);
        lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 0;
        check_eq("w_addr", s_waddr, addr);
        check_eq("w_len", s_wlen, nb - 1);
        check_eq("w_beats", s_wd.size(), nb);
        for (int k = 0; k < nb && k < s_wd.size(); k++) begin
            check_eq("w_data", s_wd[k], wd[k]);
            check_eq("w_strb", s_ws[k], ws[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        ifu_arvalid = 0; ifu_rready = 0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_wvalid = 0; lsu_wlast = 0; lsu_bready = 0;
        #1 check_eq("rst_outs", outs(), 0);
        repeat (2) @(negedge clock);
        check_eq("rst_hold", outs(), 0);
        reset = 0;
        last_side = 0;
    endtask

    task automatic idle_check(input string tag);
        #4 check_eq(tag, outs(), 0);
    endtask

    initial begin : watchdog
        #300000;
        check_eq("global_timeout", 0, 1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin : main
        int acc, beats, n;
        bit i, lr, lw;
        int pat;
        reset = 1;
        ifu_arvalid = 0; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = '0; ifu_arburst = '0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = '0; lsu_arburst = '0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = '0; lsu_awlen = '0; lsu_awsize = '0; lsu_awburst = '0;
        lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 0; lsu_bready = 0;
        do_reset();

        // IFU-only 4-beat read with latency check
        rd_req(0, 32'h3000_0000, 8'd3, 1'b1);
        idle_check("idle_after_rlast");
        predict(1, 0, 0);
        compare_order();

        // IFU/LSU tie from reset, then LSU alone, then the tie again
        do_reset();
        fork
            rd_req(0, 32'h3000_0100, 8'd1, 1'b0);
            rd_req(1, 32'h8000_0040, 8'd0, 1'b0);
        join
        predict(1, 1, 0);
        rd_req(1, 32'h8000_0080, 8'd2, 1'b0);
        predict(0, 1, 0);
        fork
            rd_req(0, 32'h3000_0200, 8'd0, 1'b0);
            rd_req(1, 32'h8000_00C0, 8'd1, 1'b0);
        join
        predict(1, 1, 0);
        compare_order();

        // Write with W presented two cycles before AW
        b_resp_cfg = 2'b00;
        wr_req(32'h1000_0000, 1, 2, 32'h41, 4'h1, 1'b0);
        idle_check("idle_after_b");
        predict(0, 0, 1);
        compare_order();

        // LSU AW and AR together: write first
        fork
            wr_req(32'h8000_1000, 2, 0, 32'h0, 4'h0, 1'b1);
            rd_req(1, 32'h8000_2000, 8'd1, 1'b0);
        join
        predict(0, 1, 1);
        compare_order();

        // SLVERR on the last beat passes through
        last_resp = 2'b10;
        rd_req(0, 32'h3000_0300, 8'd2, 1'b0);
        idle_check("idle_after_err");
        predict(1, 0, 0);
        compare_order();
        last_resp = 2'b00;

        // Reset during beat 2 of a 4-beat read
        @(negedge clock);
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0400; ifu_arlen = 8'd3;
        ifu_arsize = 3'd2; ifu_arburst = 2'b01; ifu_rready = 1;
        acc = 0; beats = 0; n = 0;
        while (beats < 1 && n < 100) begin
            #4;
            if (ifu_arvalid && ifu_arready) acc = 1;
            if (ifu_rvalid && ifu_rready) beats++;
            @(negedge clock);
            if (acc != 0) ifu_arvalid = 0;
            n++;
        end
        check_eq("mid_beats", beats, 1);
        #2 reset = 1;
        #1 check_eq("rst_async", outs(), 0);
        ifu_arvalid = 0; ifu_rready = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        last_side = 0;
        got_q.delete();
        rd_req(0, 32'h3000_0500, 8'd3, 1'b1);
        predict(1, 0, 0);
        compare_order();

        // Randomized mixes of simultaneous requests
        for (int it = 0; it < 40; it++) begin
            pat = $urandom_range(1, 7);
            i = pat[0]; lr = pat[1]; lw = pat[2];
            last_resp  = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            b_resp_cfg = 2'($urandom_range(0, 3));
            fork
                begin if (i)  rd_req(0, {$urandom} & ~32'h3, 8'($urandom_range(0, 7)), 1'b0); end
                begin if (lr) rd_req(1, {$urandom} & ~32'h3, 8'($urandom_range(0, 7)), 1'b0); end
                begin if (lw) wr_req({$urandom} & ~32'h3, $urandom_range(1, 4), 0, 32'h0, 4'h0, 1'b1); end
            join
            predict(i, lr, lw);
            compare_order();
            idle_check("idle_rand");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
